// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter
// Two-requester round-robin arbiter in front of a single Avalon-MM register
// slave (8-bit address, 8-bit data). One transfer is in flight at a time.
// A stalled transfer is aborted after TIMEOUT wait cycles.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   rq_read/rq_write    per-requester strobes (bit i = requester i)
//   rq_address          packed addresses, requester i at [8i+7:8i]
//   rq_writedata        packed write data, same packing
//   rq_readdata         read data, valid while the matching rq_done bit is high
//   rq_done, rq_err     one-cycle completion / timeout-abort pulses
//   grant               one-hot owner of the current transfer, 0 when idle
//   m_*                 Avalon-MM master side
//   fsm_state           current FSM state (0 IDLE, 1 BUS, 2 RESP)
//
// Handshake: a requester raises its strobe with address/data and holds all
// of them stable until it sees its rq_done or rq_err bit high, then drops
// the strobe on that edge. On the slave side a transfer completes on the
// rising edge where m_read/m_write is high and m_waitrequest is low.
module avalon_mm_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  rq_read,
  input  logic [1:0]  rq_write,
  input  logic [15:0] rq_address,
  input  logic [15:0] rq_writedata,
  output logic [7:0]  rq_readdata,
  output logic [1:0]  rq_done,
  output logic [1:0]  rq_err,
  output logic [1:0]  grant,
  output logic [7:0]  m_address,
  output logic        m_read,
  output logic        m_write,
  output logic [7:0]  m_writedata,
  input  logic [7:0]  m_readdata,
  input  logic        m_waitrequest,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The abort fires on the edge that would bring the counter to TIMEOUT,
  // so the strobe is high for exactly TIMEOUT cycles.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       last_grant;  // index of the most recently served requester
  logic       owner;       // index of the requester in flight
  logic [1:0] pending;
  logic       pick;
  logic [7:0] sel_address;
  logic [7:0] sel_writedata;

  assign fsm_state = state;
  assign pending   = rq_read | rq_write;

  // Round-robin pick: a lone requester wins; on contention the one not
  // served last wins.
  always_comb begin
    pick = 1'b0;
    if (pending[0] && pending[1]) pick = ~last_grant;
    else if (pending[1])          pick = 1'b1;
  end

  assign sel_address   = pick ? rq_address[15:8]   : rq_address[7:0];
  assign sel_writedata = pick ? rq_writedata[15:8] : rq_writedata[7:0];

  // m_read/m_write double as the latched operation: exactly one of them is
  // high for the whole BUS state, and read wins when both strobes are set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      m_read      <= 1'b0;
      m_write     <= 1'b0;
      m_address   <= 8'h00;
      m_writedata <= 8'h00;
      rq_readdata <= 8'h00;
      rq_done     <= 2'b00;
      rq_err      <= 2'b00;
      grant       <= 2'b00;
      wait_cnt    <= 8'h00;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            owner       <= pick;
            grant       <= pick ? 2'b10 : 2'b01;
            m_address   <= sel_address;
            m_writedata <= sel_writedata;
            m_read      <= rq_read[pick];
            m_write     <= ~rq_read[pick];
            state       <= BUS;
          end
        end
        BUS: begin
          if (!m_waitrequest) begin
            if (m_read) rq_readdata <= m_readdata;
            rq_done[owner] <= 1'b1;
            m_read         <= 1'b0;
            m_write        <= 1'b0;
            state          <= RESP;
          end else if (wait_cnt == WAIT_LIMIT) begin
            rq_err[owner] <= 1'b1;
            rq_readdata   <= 8'h00;
            m_read        <= 1'b0;
            m_write       <= 1'b0;
            state         <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP: begin
          rq_done    <= 2'b00;
          rq_err     <= 2'b00;
          grant      <= 2'b00;
          wait_cnt   <= 8'h00;
          last_grant <= owner;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
